// File: rtl/mmix_lsu_pkg.sv
// Shared types and helpers for the MMIX load/store engine.
// Holds the operation encoding, per-beat size codes and op decode functions.
// No logic of its own; imported by the engine and its alignment datapath.
package mmix_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LDB,  OP_LDBU, OP_LDW,  OP_LDWU,
    OP_LDT,  OP_LDTU, OP_LDO,  OP_LDHT,
    OP_STB,  OP_STBU, OP_STW,  OP_STWU,
    OP_STT,  OP_STTU, OP_STO,  OP_STHT
  } lsu_op_t;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_WYDE  = 2'd1;
  localparam logic [1:0] SIZE_TETRA = 2'd2;
  localparam logic [1:0] SIZE_OCTA  = 2'd3;

  // Access size of the whole operation (high-tetra forms are tetra accesses).
  function automatic logic [1:0] op_size(lsu_op_t op);
    case (op)
      OP_LDB, OP_LDBU, OP_STB, OP_STBU: op_size = SIZE_BYTE;
      OP_LDW, OP_LDWU, OP_STW, OP_STWU: op_size = SIZE_WYDE;
      OP_LDO, OP_STO:                   op_size = SIZE_OCTA;
      default:                          op_size = SIZE_TETRA;
    endcase
  endfunction

  function automatic logic op_is_store(lsu_op_t op);
    logic [3:0] code;
    code = op;
    op_is_store = code[3];
  endfunction

  function automatic logic op_is_signed(lsu_op_t op);
    op_is_signed = (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDT) ||
                   (op == OP_STB) || (op == OP_STW) || (op == OP_STT);
  endfunction

endpackage

// File: rtl/mmix_lsu_align.sv
// Load extraction/extension, high-tetra shifting, store datum selection, overflow check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: op (operation), ld_raw (assembled right-justified load datum), st_src ($X),
//        ld_data (register result), st_data (right-justified store datum), st_overflow.
module mmix_lsu_align
  import mmix_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [63:0] ld_raw,
  input  logic [63:0] st_src,
  output logic [63:0] ld_data,
  output logic [63:0] st_data,
  output logic        st_overflow
);

  logic [1:0] size;
  logic       sext;
  logic       is_high;

  always_comb begin
    size        = op_size(op);
    sext        = op_is_signed(op);
    is_high     = (op == OP_LDHT) || (op == OP_STHT);
    ld_data     = ld_raw;
    st_data     = st_src;
    st_overflow = 1'b0;
    case (size)
      SIZE_BYTE: begin
        ld_data     = {{56{sext & ld_raw[7]}}, ld_raw[7:0]};
        st_data     = {56'd0, st_src[7:0]};
        // Out of range when the value is not its own sign-extended low byte.
        st_overflow = sext && (st_src != {{56{st_src[7]}}, st_src[7:0]});
      end
      SIZE_WYDE: begin
        ld_data     = {{48{sext & ld_raw[15]}}, ld_raw[15:0]};
        st_data     = {48'd0, st_src[15:0]};
        st_overflow = sext && (st_src != {{48{st_src[15]}}, st_src[15:0]});
      end
      SIZE_TETRA: begin
        if (is_high) begin
          ld_data = {ld_raw[31:0], 32'd0};
          st_data = {32'd0, st_src[63:32]};
        end else begin
          ld_data     = {{32{sext & ld_raw[31]}}, ld_raw[31:0]};
          st_data     = {32'd0, st_src[31:0]};
          st_overflow = sext && (st_src != {{32{st_src[31]}}, st_src[31:0]});
        end
      end
      default: begin
        ld_data = ld_raw;
        st_data = st_src;
      end
    endcase
    // Signed decode also matches signed loads; overflow only means something for stores.
    if (!op_is_store(op)) st_overflow = 1'b0;
  end

endmodule

// File: rtl/mmix_lsu_engine.sv
// MMIX load/store engine: one request in, one or two memory beats, one tagged response out.
// Latency: zero-wait memory gives strobe +1, response +2 (+3 for two-beat octa on a 32-bit bus).
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no backpressure.
// Ports: req_* request handshake and fields, mem_* memory beat port (strobe held until
//        mem_done or timeout), resp_* writeback response valid for one cycle.
module mmix_lsu_engine
  import mmix_lsu_pkg::*;
#(
  parameter int BUS_W   = 64,
  parameter int TIMEOUT = 256,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  lsu_op_t          req_op,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic [63:0]      mem_address,
  output logic [1:0]       mem_datasize,
  output logic             mem_read,
  output logic             mem_write,
  output logic [BUS_W-1:0] mem_writedata,
  input  logic [BUS_W-1:0] mem_readdata,
  input  logic             mem_done,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_we,
  output logic [63:0]      resp_data,
  output logic             resp_overflow,
  output logic             resp_fault
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit              NARROW   = (BUS_W == 32);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BEAT2, S_RESP} state_t;

  state_t           state, state_n;
  lsu_op_t          op_q;
  logic [63:0]      addr_q, data_q, rd_buf;
  logic [TAG_W-1:0] tag_q;
  logic             fault_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic        accept, strobe, is_store, two_beat, timed_out;
  logic [1:0]  size_q;
  logic [63:0] aligned_addr, ld_data, st_data, wd64, rd64;
  logic        st_ovf;

  mmix_lsu_align u_align (
    .op          (op_q),
    .ld_raw      (rd_buf),
    .st_src      (data_q),
    .ld_data     (ld_data),
    .st_data     (st_data),
    .st_overflow (st_ovf)
  );

  always_comb begin
    accept    = (state == S_IDLE) && req_valid;
    strobe    = (state == S_ISSUE) || (state == S_BEAT2);
    is_store  = op_is_store(op_q);
    size_q    = op_size(op_q);
    two_beat  = NARROW && (size_q == SIZE_OCTA);
    timed_out = (tmo_cnt == TMO_LAST);
    rd64      = 64'(mem_readdata);
    // Low address bits below the access size are dropped, never faulted.
    case (op_size(req_op))
      SIZE_BYTE:  aligned_addr = req_addr;
      SIZE_WYDE:  aligned_addr = {req_addr[63:1], 1'b0};
      SIZE_TETRA: aligned_addr = {req_addr[63:2], 2'b0};
      default:    aligned_addr = {req_addr[63:3], 3'b0};
    endcase
    // Big-endian split: the first beat carries the high tetra.
    if (two_beat) begin
      wd64 = (state == S_BEAT2) ? {32'd0, st_data[31:0]} : {32'd0, st_data[63:32]};
    end else begin
      wd64 = st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    req_ready     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 64'd0;
    mem_datasize  = SIZE_BYTE;
    mem_writedata = '0;
    resp_valid    = 1'b0;
    resp_tag      = '0;
    resp_we       = 1'b0;
    resp_data     = 64'd0;
    resp_overflow = 1'b0;
    resp_fault    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = S_ISSUE;
      end
      S_ISSUE, S_BEAT2: begin
        mem_read     = !is_store;
        mem_write    = is_store;
        mem_address  = (state == S_BEAT2) ? addr_q + 64'd4 : addr_q;
        mem_datasize = two_beat ? SIZE_TETRA : size_q;
        if (is_store) mem_writedata = BUS_W'(wd64);
        // A completing beat wins over a timeout reached in the same cycle.
        if (mem_done) begin
          state_n = (state == S_ISSUE && two_beat) ? S_BEAT2 : S_RESP;
        end else if (timed_out) begin
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid    = 1'b1;
        resp_tag      = tag_q;
        resp_fault    = fault_q;
        resp_overflow = st_ovf;
        resp_we       = !is_store && !fault_q;
        resp_data     = (!is_store && !fault_q) ? ld_data : 64'd0;
        state_n       = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_LDB;
      addr_q  <= 64'd0;
      data_q  <= 64'd0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      tmo_cnt <= '0;
      rd_buf  <= 64'd0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= aligned_addr;
        data_q  <= req_data;
        tag_q   <= req_tag;
        fault_q <= 1'b0;
        tmo_cnt <= '0;
      end
      if (strobe) begin
        if (mem_done) begin
          // Restart the wait budget for the following beat, if any.
          tmo_cnt <= '0;
          if (two_beat && state == S_ISSUE) rd_buf[63:32] <= rd64[31:0];
          else if (two_beat)                rd_buf[31:0]  <= rd64[31:0];
          else                              rd_buf        <= rd64;
        end else if (timed_out) begin
          fault_q <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mmix_lsu_engine.sv
// Scoreboard bench for mmix_lsu_engine on a 32-bit bus with a short timeout.
// Expected beats feed a memory responder; expected responses feed a response monitor.
module tb_mmix_lsu_engine;
  import mmix_lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     req_op;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_tag;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_done;
  logic        resp_valid;
  logic [7:0]  resp_tag;
  logic        resp_we;
  logic [63:0] resp_data;
  logic        resp_overflow;
  logic        resp_fault;

  mmix_lsu_engine #(.BUS_W(32), .TIMEOUT(16), .TAG_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_done(mem_done),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_we(resp_we),
    .resp_data(resp_data), .resp_overflow(resp_overflow), .resp_fault(resp_fault)
  );

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          respond;
  } beat_t;

  typedef struct {
    logic [7:0]  tag;
    logic        we;
    logic [63:0] data;
    logic        ovf;
    logic        fault;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    force_done = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: checks each new strobe against the next expected beat.
  initial begin
    beat_t cur;
    bit    busy = 0;
    int    wait_left = 0;
    mem_done = 0;
    mem_readdata = 0;
    forever begin
      @(negedge clk);
      mem_done = 0;
      if (mem_read || mem_write) begin
        if (!busy) begin
          busy = 1;
          if (beat_q.size() == 0) begin
            fail("unexpected strobe");
            cur.respond = 0;
          end else begin
            cur = beat_q.pop_front();
            wait_left = cur.delay;
            chk("beat address", mem_address, cur.addr);
            chk("beat size", 64'(mem_datasize), 64'(cur.size));
            chk("beat write/read", 64'({mem_write, mem_read}), 64'({cur.wr, !cur.wr}));
            if (cur.wr) chk("beat writedata", 64'(mem_writedata), 64'(cur.wdata));
          end
        end
        if (cur.respond) begin
          if (wait_left == 0) begin
            mem_done = 1;
            mem_readdata = cur.rdata;
            busy = 0;
          end else begin
            wait_left--;
          end
        end
      end else begin
        busy = 0;
      end
      if (force_done) begin
        mem_done = 1;
        force_done = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          fail("unexpected response");
        end else begin
          e = resp_q.pop_front();
          chk("resp tag", 64'(resp_tag), 64'(e.tag));
          chk("resp we", 64'(resp_we), 64'(e.we));
          chk("resp data", resp_data, e.data);
          chk("resp overflow", 64'(resp_overflow), 64'(e.ovf));
          chk("resp fault", 64'(resp_fault), 64'(e.fault));
        end
      end
    end
  end

  task automatic beat(input logic [63:0] a, input logic [1:0] s, input logic wr,
                      input logic [31:0] wd, input logic [31:0] rd, input int dly,
                      input bit respond);
    beat_t b;
    b.addr = a; b.size = s; b.wr = wr; b.wdata = wd; b.rdata = rd;
    b.delay = dly; b.respond = respond;
    beat_q.push_back(b);
  endtask

  task automatic expect_resp(input logic [7:0] t, input logic we, input logic [63:0] d,
                             input logic ovf, input logic flt);
    resp_t r;
    r.tag = t; r.we = we; r.data = d; r.ovf = ovf; r.fault = flt;
    resp_q.push_back(r);
  endtask

  // Returns at the negedge of the first strobe cycle.
  task automatic issue(input lsu_op_t op, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] t);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = a; req_data = d; req_tag = t;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("req_ready never rose");
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (resp_q.size() != 0 || beat_q.size() != 0) fail("response wait expired");
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1; req_valid = 0; req_op = OP_LDB; req_addr = 0; req_data = 0; req_tag = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset mem_address", mem_address, 64'd0);
    chk("reset resp_data", resp_data, 64'd0);

    // LDB sign-extends; zero-wait latency checked cycle by cycle.
    beat(64'h1003, SIZE_BYTE, 0, 0, 32'h80, 0, 1);
    expect_resp(8'h11, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
    issue(OP_LDB, 64'h1003, 0, 8'h11);
    @(negedge clk);
    chk("single beat resp latency", 64'(resp_valid), 64'd1);
    @(negedge clk);
    chk("ready after response", 64'(req_ready), 64'd1);
    wait_done();

    beat(64'h1002, SIZE_WYDE, 0, 0, 32'h8001, 1, 1);
    expect_resp(8'h12, 1, 64'h0000_0000_0000_8001, 0, 0);
    issue(OP_LDWU, 64'h1003, 0, 8'h12);
    wait_done();

    beat(64'h1004, SIZE_TETRA, 0, 0, 32'h1234_5678, 2, 1);
    expect_resp(8'h13, 1, 64'h1234_5678_0000_0000, 0, 0);
    issue(OP_LDHT, 64'h1006, 0, 8'h13);
    wait_done();

    beat(64'h4000, SIZE_TETRA, 0, 0, 32'h8000_0000, 0, 1);
    expect_resp(8'h14, 1, 64'hFFFF_FFFF_8000_0000, 0, 0);
    issue(OP_LDT, 64'h4002, 0, 8'h14);
    wait_done();

    beat(64'h4004, SIZE_TETRA, 0, 0, 32'h8000_0000, 0, 1);
    expect_resp(8'h15, 1, 64'h0000_0000_8000_0000, 0, 0);
    issue(OP_LDTU, 64'h4007, 0, 8'h15);
    wait_done();

    // Stores: datum selection and signed-range overflow.
    beat(64'h3001, SIZE_BYTE, 1, 32'h34, 0, 0, 1);
    expect_resp(8'h21, 0, 0, 1, 0);
    issue(OP_STB, 64'h3001, 64'h1234, 8'h21);
    wait_done();

    beat(64'h3001, SIZE_BYTE, 1, 32'h34, 0, 0, 1);
    expect_resp(8'h22, 0, 0, 0, 0);
    issue(OP_STBU, 64'h3001, 64'h1234, 8'h22);
    wait_done();

    beat(64'h3004, SIZE_TETRA, 1, 32'h8000_0000, 0, 1, 1);
    expect_resp(8'h23, 0, 0, 0, 0);
    issue(OP_STT, 64'h3007, 64'hFFFF_FFFF_8000_0000, 8'h23);
    wait_done();

    beat(64'h3006, SIZE_WYDE, 1, 32'h8000, 0, 0, 1);
    expect_resp(8'h24, 0, 0, 0, 0);
    issue(OP_STW, 64'h3007, 64'hFFFF_FFFF_FFFF_8000, 8'h24);
    wait_done();

    beat(64'h3006, SIZE_WYDE, 1, 32'h8000, 0, 0, 1);
    expect_resp(8'h25, 0, 0, 1, 0);
    issue(OP_STW, 64'h3006, 64'h0000_0000_0000_8000, 8'h25);
    wait_done();

    beat(64'h5000, SIZE_TETRA, 1, 32'hDEAD_BEEF, 0, 0, 1);
    expect_resp(8'h26, 0, 0, 0, 0);
    issue(OP_STHT, 64'h5003, 64'hDEAD_BEEF_0000_0000, 8'h26);
    wait_done();

    // Two-beat octa on the 32-bit bus, high tetra first.
    beat(64'h2000, SIZE_TETRA, 0, 0, 32'h0123_4567, 0, 1);
    beat(64'h2004, SIZE_TETRA, 0, 0, 32'h89AB_CDEF, 0, 1);
    expect_resp(8'h31, 1, 64'h0123_4567_89AB_CDEF, 0, 0);
    issue(OP_LDO, 64'h2005, 0, 8'h31);
    @(negedge clk);
    chk("two beat second address", mem_address, 64'h2004);
    @(negedge clk);
    chk("two beat resp latency", 64'(resp_valid), 64'd1);
    wait_done();

    beat(64'h2000, SIZE_TETRA, 1, 32'h0123_4567, 0, 2, 1);
    beat(64'h2004, SIZE_TETRA, 1, 32'h89AB_CDEF, 0, 1, 1);
    expect_resp(8'h32, 0, 0, 0, 0);
    issue(OP_STO, 64'h2005, 64'h0123_4567_89AB_CDEF, 8'h32);
    wait_done();

    // Timeout on a single beat, then a stray late mem_done.
    beat(64'h6000, SIZE_BYTE, 0, 0, 32'hFF, 0, 0);
    expect_resp(8'h41, 0, 0, 0, 1);
    issue(OP_LDB, 64'h6000, 0, 8'h41);
    n = 0;
    while ((mem_read || mem_write) && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout strobe cycles", 64'(n), 64'd16);
    repeat (3) @(negedge clk);
    force_done = 1;
    repeat (4) @(negedge clk);
    chk("idle after late done", 64'(req_ready), 64'd1);
    chk("no strobe after late done", 64'({mem_read, mem_write}), 64'd0);
    chk("timeout response consumed", 64'(resp_q.size()), 64'd0);

    // Timeout on the second beat of a store.
    beat(64'h7000, SIZE_TETRA, 1, 32'hCAFE_F00D, 0, 0, 1);
    beat(64'h7004, SIZE_TETRA, 1, 32'h1357_9BDF, 0, 0, 0);
    expect_resp(8'h42, 0, 0, 0, 1);
    issue(OP_STO, 64'h7000, 64'hCAFE_F00D_1357_9BDF, 8'h42);
    wait_done();

    // Reset in the middle of an access.
    beat(64'h8000, SIZE_BYTE, 0, 0, 0, 0, 0);
    issue(OP_LDB, 64'h8000, 0, 8'h51);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("reset mid access strobe", 64'({mem_read, mem_write}), 64'd0);
    chk("reset mid access resp_valid", 64'(resp_valid), 64'd0);
    chk("reset mid access ready", 64'(req_ready), 64'd1);

    beat(64'h2008, SIZE_TETRA, 0, 0, 32'hA5A5_0001, 0, 1);
    beat(64'h200C, SIZE_TETRA, 0, 0, 32'h5A5A_0002, 1, 1);
    expect_resp(8'h52, 1, 64'hA5A5_0001_5A5A_0002, 0, 0);
    issue(OP_LDO, 64'h200F, 0, 8'h52);
    wait_done();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mmix_lsu_engine.md
# mmix_lsu_engine

Parametrised load/store engine for the MMIX core, successor to `ld_st_unit`. It accepts one fully-computed memory request (effective address already `y+z`) through a valid/ready handshake. It applies MMIX alignment, size, sign-extension, store-overflow and high-tetra rules, and drives the memory port, splitting octas into two beats when the memory bus is 32 bits. It adds a bus timeout that returns a fault, and returns one tagged response for the register writeback stage.

## Interface
- `BUS_W`, 64: memory data bus width; legal values 64 or 32.
- `TIMEOUT`, 256: cycles a strobe may wait for `mem_done` before the access is aborted; ≥2.
- `TAG_W`, 8: width of the request/response tag (destination register number).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle, can accept a request.
- `req_op` in 4: `lsu_op_t` operation.
- `req_addr` in 64: effective address.
- `req_data` in 64: store value (`$X`).
- `req_tag` in TAG_W: destination tag.
- `mem_address` out 64: aligned beat address.
- `mem_datasize` out 2: 0 byte, 1 wyde, 2 tetra, 3 octa (per beat).
- `mem_read` out 1, `mem_write` out 1: beat strobes.
- `mem_writedata` out BUS_W: right-justified store datum.
- `mem_readdata` in BUS_W: right-justified load datum, valid with `mem_done`.
- `mem_done` in 1: beat complete.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_tag` out TAG_W: echoes `req_tag`.
- `resp_we` out 1: register write required (loads without fault).
- `resp_data` out 64: load result, else 0.
- `resp_overflow` out 1: signed store value out of range.
- `resp_fault` out 1: access timed out.

## Operation
- Reset values: `req_ready`=1; all other outputs 0; FSM in IDLE.
- Ops: LDB, LDBU, LDW, LDWU, LDT, LDTU, LDO, LDHT, STB, STBU, STW, STWU, STT, STTU, STO, STHT.
- Size: B=1, W=2, T=4 and HT=4, O=8 bytes. The address is aligned down to size (`addr & ~(size-1)`); low bits are ignored, never faulted.
- Loads:
  - Signed forms sign-extend to 64; U forms zero-extend; LDO is raw.
  - LDHT returns `datum<<32`.
- Stores:
  - `mem_writedata` = low size bytes of `req_data`, upper bits zero. STHT writes `req_data[63:32]` as a tetra.
  - STB, STW and STT set `resp_overflow` when `req_data` is outside the signed range of the size. The write still happens.
  - U forms, STO and STHT never overflow.
- Multi-beat: when BUS_W=32, LDO and STO run two tetra beats. Beat 0 goes to the aligned address A and carries the high tetra (big-endian). Beat 1 goes to A+4 and carries the low tetra. All other ops are single-beat at either width.
- FSM:
  - IDLE→ISSUE on handshake.
  - ISSUE: hold the strobe, address, size and write data. On `mem_done`, go to BEAT2 if a second beat is needed, else RESP. On timeout, go to RESP with fault.
  - BEAT2 behaves like ISSUE for beat 1.
  - RESP pulses `resp_valid` and then returns to IDLE.
- Timeout:
  - A counter clears at each strobe start and increments while the strobe waits.
  - When it reaches TIMEOUT, the strobe drops and the engine goes to RESP with `resp_fault`=1, `resp_we`=0 and `resp_data`=0.
  - A late `mem_done` in IDLE or RESP is ignored.
- Fault on beat 1 of a two-beat store: beat 0 stays written; the fault is still reported.

## Timing
- `req_ready` is high only in IDLE. A request is accepted on the edge where `req_valid & req_ready`, and request fields are latched on that edge.
- A strobe is asserted the cycle after acceptance. It stays stable until the cycle in which `mem_done`=1 is sampled, then deasserts (or moves to beat 1) on the next edge. There is no idle cycle between beats.
- With zero-wait memory (`mem_done` in the first strobe cycle):
  - Single beat: strobe in cycle 1, `resp_valid` in cycle 2, `req_ready` in cycle 3.
  - Two beats: `resp_valid` in cycle 3.
- `resp_*` fields are valid only while `resp_valid`=1; otherwise they are 0. There is no backpressure.
- `mem_done` while no strobe is active is ignored.
- Reset mid-access: strobes and `resp_valid` are 0 from the next edge; no response is issued for the aborted request.

## Structure
- `mmix_lsu_pkg` holds:
  - `lsu_op_t` (4-bit enum in the order above);
  - the size-code constants;
  - the functions `op_size`, `op_is_store`, `op_is_signed`.
- Sub-module `mmix_lsu_align` is combinational. It does load extraction/extension, LDHT shift, store datum selection and the overflow check. The engine holds the FSM, beat sequencing and timeout counter.

## Test plan
- LDB, addr 0x1003, readdata 0x80 → `mem_address` 0x1003, size 0, `resp_data` 0xFFFFFFFFFFFFFF80, `resp_we`=1.
- LDWU, addr 0x1003, readdata 0x8001 → `mem_address` 0x1002, `resp_data` 0x0000000000008001; LDHT readdata 0x12345678 → 0x1234567800000000.
- STB, data 0x1234 → `mem_writedata` 0x34, `resp_overflow`=1; STBU with the same data → `resp_overflow`=0; STT with data 0xFFFFFFFF80000000 → overflow 0.
- BUS_W=32, LDO, addr 0x2005, beats return 0x01234567 then 0x89ABCDEF → addresses 0x2000/0x2004, `resp_data` 0x0123456789ABCDEF; STO mirrors this.
- TIMEOUT=16, no `mem_done` → strobe drops after 16 cycles, `resp_fault`=1, `resp_we`=0; a `mem_done` three cycles later is ignored.
- `reset` asserted during ISSUE → strobe 0 next cycle, no `resp_valid`, `req_ready`=1, and the next LDO completes normally.
